scan_sequencer: RTL and testbench
=================================

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 16, width of the dwell prescaler.
REQ-002 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port en  input  1  run enable.
REQ-005 SHALL have port mode  input  1  0 = timed (prescaler) advance, 1 = single-step advance.
REQ-006 SHALL have port step  input  1  single-step advance request, level-sampled each cycle.
REQ-007 SHALL have port div  input  DIV_WIDTH  dwell length in cycles.
REQ-008 SHALL have port sel_ready  input  1  downstream decoder accepts sel.
REQ-009 SHALL have port sel  output  2  index for the 2-to-4 one-hot decoder; sel[1] drives x, sel[0] drives y.
REQ-010 SHALL have port sel_valid  output  1  sel is being presented.
REQ-011 SHALL have port tick  output  1  one-cycle pulse after each accepted transfer.
REQ-012 SHALL have port wrap  output  1  one-cycle pulse when sel changes 3 -> 0.
REQ-013 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL implement an FSM with states IDLE, PRESENT, DWELL and STEPWAIT; all outputs SHALL be registered.
REQ-015 SHALL assert sel_valid only in PRESENT.
REQ-016 SHALL define a transfer as a cycle with sel_valid=1 and sel_ready=1.
REQ-017 SHALL hold sel and sel_valid stable in PRESENT until a transfer occurs; valid is never withdrawn, including when en=0.
REQ-018 In IDLE with en=1, SHALL enter PRESENT with sel unchanged; with en=0 SHALL stay in IDLE.
REQ-019 On a transfer with en=1 and mode=0, SHALL enter DWELL, loading the counter with div; div and mode are sampled only at the transfer.
REQ-020 On a transfer with en=1 and mode=1, SHALL enter STEPWAIT.
REQ-021 On a transfer with en=0, SHALL enter IDLE and increment sel.
REQ-022 In DWELL with a nonzero counter, SHALL decrement the counter each cycle.
REQ-023 In DWELL with counter=0, SHALL increment sel and enter PRESENT.
  - sel_valid SHALL rise exactly div+2 cycles after the transfer cycle.
REQ-024 In STEPWAIT with step=1, SHALL increment sel and enter PRESENT.
REQ-025 SHALL ignore step in every state other than STEPWAIT.
REQ-026 In DWELL or STEPWAIT with en=0, SHALL increment sel and enter IDLE immediately.
  - en=0 takes priority over counter=0 and over step.
  - Net effect: IDLE always holds the next index not yet transferred.
REQ-027 SHALL increment sel modulo 4, wrapping 3 -> 0.
REQ-028 SHALL assert wrap for exactly the one cycle in which sel first reads 0 after a wrap.
REQ-029 SHALL assert tick for exactly one cycle, the cycle after each transfer.
REQ-030 With div=0, DWELL SHALL last exactly one cycle, giving a minimum transfer spacing of 2 cycles.

Reset
REQ-031 With rst=1 at a clock edge, the next cycle SHALL show state IDLE, sel=0, sel_valid=0, tick=0, wrap=0, busy=0 and counter=0.
REQ-032 rst SHALL take priority over all other inputs in any state, including mid-DWELL and mid-PRESENT; no pending tick or wrap pulse survives reset.

Verification
REQ-033 Timed run: rst, then en=1, mode=0, div=2, sel_ready=1 held -> sel presents 0,1,2,3,0, each valid 1 cycle, consecutive valids 4 cycles apart; wrap=1 with the second sel=0; tick once per transfer.
REQ-034 Backpressure: sel_ready=0 for 5 cycles while sel=1 is presented -> sel=1 and sel_valid=1 held for all 5 cycles, no tick; transfer on the cycle sel_ready rises.
REQ-035 Single-step: mode=1, sel_ready=1, step pulses at irregular spacing plus one step while sel_valid=1 -> sel advances by exactly 1 per step taken in STEPWAIT; the step during PRESENT has no effect.
REQ-036 Disable mid-dwell: div=10, en dropped 3 cycles after the sel=1 transfer -> next cycle IDLE, busy=0, sel=2; en reasserted -> sel=2 presented.
REQ-037 Reset mid-operation: rst pulsed in DWELL with sel=2 -> next cycle sel=0, sel_valid=0, busy=0; after rst, en=1 presents sel=0.
REQ-038 Minimum spacing: div=0, sel_ready=1 -> sel_valid high every 2nd cycle; sel sequence 0,1,2,3,0 with a wrap pulse.

Source files
------------

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - scan index sequencer driving a 2-to-4 one-hot decoder
// Presents sel with valid/ready, then dwells (timed) or waits for a step before advancing.
module scan_sequencer #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 step,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 sel_ready,
    output logic [1:0]           sel,
    output logic                 sel_valid,
    output logic                 tick,
    output logic                 wrap,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESENT  = 2'd1,
        DWELL    = 2'd2,
        STEPWAIT = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           sel_q, sel_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 sel_valid_q, sel_valid_d;
    logic                 tick_q, tick_d;
    logic                 wrap_q, wrap_d;
    logic                 busy_q, busy_d;
    logic                 xfer;
    logic                 adv;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adv     = 1'b0;
        xfer    = (state_q == PRESENT) && sel_ready;

        case (state_q)
            IDLE: begin
                if (en) state_d = PRESENT;
            end
            PRESENT: begin
                if (xfer) begin
                    if (!en) begin
                        state_d = IDLE;
                        adv     = 1'b1;
                    end else if (!mode) begin
                        state_d = DWELL;
                        cnt_d   = div;
                    end else begin
                        state_d = STEPWAIT;
                    end
                end
            end
            DWELL: begin
                // Dropping en wins over an expiring counter so IDLE always holds the next index.
                if (!en) begin
                    state_d = IDLE;
                    adv     = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = PRESENT;
                    adv     = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STEPWAIT: begin
                if (!en || step) begin
                    state_d = en ? PRESENT : IDLE;
                    adv     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        sel_d       = adv ? sel_q + 2'd1 : sel_q;
        sel_valid_d = (state_d == PRESENT);
        busy_d      = (state_d != IDLE);
        tick_d      = xfer;
        wrap_d      = adv && (sel_q == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= 2'd0;
            cnt_q       <= '0;
            sel_valid_q <= 1'b0;
            tick_q      <= 1'b0;
            wrap_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            sel_valid_q <= sel_valid_d;
            tick_q      <= tick_d;
            wrap_q      <= wrap_d;
            busy_q      <= busy_d;
        end
    end

    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
    assign tick      = tick_q;
    assign wrap      = wrap_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - self-checking bench for scan_sequencer
module tb_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        mode = 1'b0;
    logic        step = 1'b0;
    logic [15:0] div = 16'd0;
    logic        sel_ready = 1'b0;
    logic [1:0]  sel;
    logic        sel_valid;
    logic        tick;
    logic        wrap;
    logic        busy;

    int checks = 0;
    int failures = 0;

    scan_sequencer #(.DIV_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .step      (step),
        .div       (div),
        .sel_ready (sel_ready),
        .sel       (sel),
        .sel_valid (sel_valid),
        .tick      (tick),
        .wrap      (wrap),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic clk_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; en = 1'b0; mode = 1'b0; step = 1'b0; sel_ready = 1'b0; div = 16'd0;
        clk_cycle;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; mode = 1'b0; step = 1'b1; sel_ready = 1'b1; div = 16'd5;
        clk_cycle;
        clk_cycle;
        checks++;
        if ({sel, sel_valid, tick, wrap, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got sel=%0d valid=%b tick=%b wrap=%b busy=%b exp all zero",
                     sel, sel_valid, tick, wrap, busy);
        end
        rst = 1'b0; step = 1'b0;
    endtask

    // Five presentations under constant en/ready; spacing must be d+2, wrap on the second 0.
    task automatic test_timed(input int d);
        int         times[5];
        logic [1:0] sels[5];
        logic       wrap_at[5];
        int         nv, nticks, nwraps;
        do_reset;
        en = 1'b1; mode = 1'b0; div = 16'(d); sel_ready = 1'b1;
        nv = 0; nticks = 0; nwraps = 0;
        for (int c = 0; c < 60 && nv < 5; c++) begin
            clk_cycle;
            nticks += int'(tick);
            nwraps += int'(wrap);
            if (sel_valid) begin
                times[nv] = c; sels[nv] = sel; wrap_at[nv] = wrap; nv++;
            end
        end
        clk_cycle;
        nticks += int'(tick);
        checks++;
        if (nv != 5) begin
            failures++;
            $display("FAIL timed_count div=%0d got=%0d valids exp=5", d, nv);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (sels[i] !== 2'(i % 4)) begin
                    failures++;
                    $display("FAIL timed_sel div=%0d idx=%0d got=%0d exp=%0d", d, i, sels[i], i % 4);
                end
                if (i > 0) begin
                    checks++;
                    if (times[i] - times[i-1] != d + 2) begin
                        failures++;
                        $display("FAIL timed_spacing div=%0d idx=%0d got=%0d exp=%0d",
                                 d, i, times[i] - times[i-1], d + 2);
                    end
                end
            end
            checks++;
            if (!(wrap_at[4] === 1'b1 && nwraps == 1)) begin
                failures++;
                $display("FAIL timed_wrap div=%0d got wrap_at_5th=%b count=%0d exp 1/1", d, wrap_at[4], nwraps);
            end
            checks++;
            if (nticks != 5) begin
                failures++;
                $display("FAIL timed_ticks div=%0d got=%0d exp=5", d, nticks);
            end
        end
    endtask

    task automatic test_backpressure;
        int c;
        do_reset;
        en = 1'b1; mode = 1'b0; div = 16'd1; sel_ready = 1'b1;
        c = 0;
        do begin clk_cycle; c++; end while (!sel_valid && c < 20);
        clk_cycle;
        sel_ready = 1'b0;
        c = 0;
        while (!sel_valid && c < 20) begin clk_cycle; c++; end
        checks++;
        if (!(sel_valid === 1'b1 && sel === 2'd1)) begin
            failures++;
            $display("FAIL bp_present got valid=%b sel=%0d exp 1/1", sel_valid, sel);
        end
        for (int i = 0; i < 5; i++) begin
            clk_cycle;
            checks++;
            if (!(sel_valid === 1'b1 && sel === 2'd1 && tick === 1'b0)) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got valid=%b sel=%0d tick=%b exp 1/1/0", i, sel_valid, sel, tick);
            end
        end
        sel_ready = 1'b1;
        clk_cycle;
        checks++;
        if (!(tick === 1'b1 && sel_valid === 1'b0)) begin
            failures++;
            $display("FAIL bp_release got tick=%b valid=%b exp 1/0", tick, sel_valid);
        end
    endtask

    task automatic test_step;
        logic [1:0] exp_sel;
        int gap;
        do_reset;
        en = 1'b1; mode = 1'b1; sel_ready = 1'b1; div = 16'd7;
        clk_cycle;
        exp_sel = 2'd0;
        for (int n = 0; n < 6; n++) begin
            checks++;
            if (!(sel_valid === 1'b1 && sel === exp_sel)) begin
                failures++;
                $display("FAIL step_present n=%0d got valid=%b sel=%0d exp 1/%0d", n, sel_valid, sel, exp_sel);
            end
            step = (n % 2 == 0);
            clk_cycle;
            step = 1'b0;
            gap = $urandom_range(0, 3);
            for (int g = 0; g <= gap; g++) begin
                checks++;
                if (!(sel_valid === 1'b0 && sel === exp_sel && busy === 1'b1)) begin
                    failures++;
                    $display("FAIL step_wait n=%0d got valid=%b sel=%0d busy=%b exp 0/%0d/1",
                             n, sel_valid, sel, busy, exp_sel);
                end
                if (g < gap) clk_cycle;
            end
            step = 1'b1;
            clk_cycle;
            step = 1'b0;
            exp_sel = exp_sel + 2'd1;
        end
    endtask

    task automatic test_disable_mid_dwell;
        int c;
        do_reset;
        en = 1'b1; mode = 1'b0; div = 16'd10; sel_ready = 1'b1;
        c = 0;
        do begin clk_cycle; c++; end while (!(sel_valid && sel == 2'd1) && c < 40);
        clk_cycle; clk_cycle; clk_cycle;
        en = 1'b0;
        clk_cycle;
        checks++;
        if (!(busy === 1'b0 && sel === 2'd2 && sel_valid === 1'b0)) begin
            failures++;
            $display("FAIL dis_idle got busy=%b sel=%0d valid=%b exp 0/2/0", busy, sel, sel_valid);
        end
        en = 1'b1;
        clk_cycle;
        checks++;
        if (!(sel_valid === 1'b1 && sel === 2'd2)) begin
            failures++;
            $display("FAIL dis_resume got valid=%b sel=%0d exp 1/2", sel_valid, sel);
        end
    endtask

    task automatic test_reset_mid;
        int c;
        do_reset;
        en = 1'b1; mode = 1'b0; div = 16'd3; sel_ready = 1'b1;
        c = 0;
        do begin clk_cycle; c++; end while (!(busy && !sel_valid && sel == 2'd2) && c < 40);
        rst = 1'b1;
        clk_cycle;
        checks++;
        if ({sel, sel_valid, busy, tick, wrap} !== 6'b0) begin
            failures++;
            $display("FAIL rstmid_state got sel=%0d valid=%b busy=%b tick=%b wrap=%b exp all zero",
                     sel, sel_valid, busy, tick, wrap);
        end
        rst = 1'b0;
        clk_cycle;
        checks++;
        if (!(sel_valid === 1'b1 && sel === 2'd0)) begin
            failures++;
            $display("FAIL rstmid_resume got valid=%b sel=%0d exp 1/0", sel_valid, sel);
        end
    endtask

    // Reference: every presented or idle index equals transfers-since-reset mod 4,
    // tick follows each transfer, and an uninterrupted timed dwell lasts div+2 cycles.
    task automatic test_random;
        int          cnt, k, dv;
        bit          live;
        logic        pv, pr, xfer, en_a, mode_a;
        logic [1:0]  ps;
        logic [15:0] div_a;
        do_reset;
        cnt = 0; live = 0; k = 0; dv = 0;
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom % 10) != 0;
            if ($urandom % 16 == 0) mode = ~mode;
            step      = ($urandom % 3) == 0;
            sel_ready = ($urandom % 4) != 0;
            div       = 16'($urandom % 4);
            pv = sel_valid; ps = sel; pr = sel_ready; xfer = pv && pr;
            en_a = en; mode_a = mode; div_a = div;
            clk_cycle;
            checks++;
            if (tick !== xfer) begin
                failures++;
                $display("FAIL rnd_tick cyc=%0d got=%b exp=%b", i, tick, xfer);
            end
            if (live) begin
                k++;
                if (!en_a) live = 0;
                else if (k < dv + 2) begin
                    checks++;
                    if (sel_valid !== 1'b0) begin
                        failures++;
                        $display("FAIL rnd_dwell_early cyc=%0d k=%0d got=%b exp=0", i, k, sel_valid);
                    end
                end else begin
                    checks++;
                    if (sel_valid !== 1'b1) begin
                        failures++;
                        $display("FAIL rnd_dwell_end cyc=%0d div=%0d got=%b exp=1", i, dv, sel_valid);
                    end
                    live = 0;
                end
            end
            if (xfer) begin
                cnt++;
                if (en_a && !mode_a) begin
                    live = 1; k = 1; dv = int'(div_a);
                    if (dv + 2 == 1) live = 0;
                end
            end
            if (pv && !pr) begin
                checks++;
                if (!(sel_valid === 1'b1 && sel === ps)) begin
                    failures++;
                    $display("FAIL rnd_hold cyc=%0d got valid=%b sel=%0d exp 1/%0d", i, sel_valid, sel, ps);
                end
            end
            if (sel_valid || !busy) begin
                checks++;
                if (sel !== 2'(cnt % 4)) begin
                    failures++;
                    $display("FAIL rnd_index cyc=%0d got=%0d exp=%0d", i, sel, cnt % 4);
                end
            end
            checks++;
            if (wrap !== (sel == 2'd0 && ps == 2'd3)) begin
                failures++;
                $display("FAIL rnd_wrap cyc=%0d got=%b prev=%0d now=%0d", i, wrap, ps, sel);
            end
            checks++;
            if (!busy && sel_valid !== 1'b0) begin
                failures++;
                $display("FAIL rnd_busy cyc=%0d got valid=%b with busy=0 exp valid=0", i, sel_valid);
            end
        end
    endtask

    initial begin
        test_reset;
        test_timed(2);
        test_backpressure;
        test_step;
        test_disable_mid_dwell;
        test_reset_mid;
        test_timed(0);
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
